marsohod2bis_rst_sequencer: RTL
===============================

// Module: marsohod2bis_rst_sequencer
// PURPOSE
//  Board-level reset sequencer between altpll_clkgen/KEY0 and the picorv32 Wishbone SoC.
//  Synchronises PLL lock and raw KEY0, debounces the key, distinguishes short/long press,
//  and releases sdram_rst then wb_rst in order. Long press or PLL lock loss re-runs the sequence.
// PARAMETERS
//  CNT_WIDTH         25        width of debounce/press/sequence counters
//  DEBOUNCE_CYCLES   480000    consecutive stable cycles before debounced key changes (20 ms @ 24 MHz)
//  LONGPRESS_CYCLES  24000000  press duration (debounced) that forces reset (1 s @ 24 MHz)
//  SDRAM_RST_CYCLES  16        cycles sdram_rst_o held after lock+key released
//  WB_RST_CYCLES     16        cycles wb_rst_o held after sdram_rst_o release
// PORTS
//  sys_clk_pad_i  in   1  single clock, all logic on rising edge
//  rst_n_pad_i    in   1  asynchronous active-low reset
//  key_n_i        in   1  raw KEY0, low = pressed, asynchronous
//  pll_locked_i   in   1  PLL lock, asynchronous
//  sdram_rst_o    out  1  SDRAM controller reset, active high
//  wb_rst_o       out  1  Wishbone/CPU reset, active high
//  key_evt_o      out  1  one-cycle pulse: short press completed
//  rst_cause_o    out  2  0 power-on, 1 PLL lock loss, 2 key long press; 3 unused
// BEHAVIOUR
//  Reset (rst_n_pad_i=0, async): sdram_rst_o=1, wb_rst_o=1, key_evt_o=0, rst_cause_o=0,
//   sync FFs=0 (lock) / 1 (key), key_db=1 (released), all counters 0, state=S_RESET.
//  Sync: 2-FF synchroniser on key_n_i and pll_locked_i -> key_s, lock_s (2-cycle latency).
//  Debounce: key_s==key_db -> db_cnt=0; else db_cnt++; when db_cnt==DEBOUNCE_CYCLES-1 and
//   still differing, key_db<=key_s, db_cnt<=0. Flip after exactly DEBOUNCE_CYCLES differing cycles.
//  Press counter: key_db=0 -> press_cnt++ saturating at LONGPRESS_CYCLES; key_db=1 -> 0.
//   long_press = (press_cnt==LONGPRESS_CYCLES-1) && key_db==0 (single-cycle event per press).
//  key_evt_o: 1 for one cycle on key_db 0->1 when press_cnt<LONGPRESS_CYCLES and state==S_RUN.
//  FSM (registered outputs, change on the clock after the transition condition):
//   S_RESET:      sdram_rst=1, wb_rst=1; lock_s=1 && key_db=1 -> S_SDRAM_HOLD, seq_cnt=0.
//   S_SDRAM_HOLD: count SDRAM_RST_CYCLES; on last -> S_WB_HOLD, sdram_rst_o<=0, seq_cnt=0.
//   S_WB_HOLD:    count WB_RST_CYCLES; on last -> S_RUN, wb_rst_o<=0.
//   S_RUN:        both resets 0.
//   Any state but S_RESET: lock_s=0 -> S_RESET, cause<=1; else long_press -> S_RESET, cause<=2.
//   Both resets reassert on the same edge that enters S_RESET.
//  Simultaneous lock loss + long press: lock loss wins, cause=1.
//  Lock loss while in S_RESET: no cause update; cause retained until next S_RESET entry.
//  Long press held: S_RESET persists until key debounced released; no key_evt_o for that release.
//  Counters never wrap: seq_cnt cleared on each hold-state entry, press_cnt saturates.
//  CNT_WIDTH must hold max(DEBOUNCE,LONGPRESS,SDRAM_RST,WB_RST)_CYCLES; all params >=1.
// TESTING (bench params: DEBOUNCE=4, LONGPRESS=20, SDRAM_RST=3, WB_RST=5)
//  Power-up: rst_n low 5 cyc, key high, lock rises at T -> sdram_rst_o falls ~T+6, wb_rst_o
//   ~T+11 (exact edge per FSM above), cause=0, key_evt_o never pulses.
//  Bounce: in S_RUN, key low 3 cycles then high -> key_db unchanged, no key_evt_o, resets stay 0.
//  Short press: key low 10 cycles in S_RUN -> exactly one key_evt_o pulse ~6 cycles after release.
//  Long press: key low 40 cycles -> both resets 1 at press_cnt=19, cause=2, held until debounced
//   release, then sdram_rst_o drops after 3, wb_rst_o after 5 more; no key_evt_o.
//  Lock glitch: pll_locked_i low 2 cycles in S_RUN -> resets reassert, cause=1, resequence;
//   same cycle as long_press -> cause=1.
//  Async reset mid S_WB_HOLD -> all outputs at reset values immediately, cause=0, restart sequence.

Source files
------------

// File: rtl/marsohod2bis_rst_sequencer.sv
// -----------------------------------------------------------------------------
// marsohod2bis_rst_sequencer
//
// Board-level reset sequencer. It sits between the PLL clock generator and the
// KEY0 push button on one side, and the picorv32 Wishbone SoC on the other.
//
//  * PLL lock and the raw key are brought into the sys_clk domain through
//    2-FF synchronisers.
//  * The key is debounced. A debounced press is either short or long:
//      - a short press produces a one-cycle key_evt_o pulse when it is released;
//      - a long press forces a full reset.
//  * SDRAM reset is released first, then the Wishbone/CPU reset.
//  * Losing PLL lock, or a long key press, re-runs the whole sequence.
//    rst_cause_o records why the last reset happened.
//
// Ports
//  sys_clk_pad_i  in   1  single clock, all logic on the rising edge
//  rst_n_pad_i    in   1  asynchronous active-low reset
//  key_n_i        in   1  raw KEY0, low = pressed, asynchronous to sys_clk
//  pll_locked_i   in   1  PLL lock, asynchronous to sys_clk
//  sdram_rst_o    out  1  SDRAM controller reset, active high
//  wb_rst_o       out  1  Wishbone/CPU reset, active high
//  key_evt_o      out  1  one-cycle pulse when a short press completes
//  rst_cause_o    out  2  0 power-on, 1 PLL lock loss, 2 key long press
//
// CNT_WIDTH must be wide enough to hold the largest of the four *_CYCLES
// parameters. Every *_CYCLES parameter must be at least 1.
// -----------------------------------------------------------------------------
module marsohod2bis_rst_sequencer #(
  parameter int CNT_WIDTH        = 25,
  parameter int DEBOUNCE_CYCLES  = 480000,
  parameter int LONGPRESS_CYCLES = 24000000,
  parameter int SDRAM_RST_CYCLES = 16,
  parameter int WB_RST_CYCLES    = 16
) (
  input  logic       sys_clk_pad_i,
  input  logic       rst_n_pad_i,
  input  logic       key_n_i,
  input  logic       pll_locked_i,
  output logic       sdram_rst_o,
  output logic       wb_rst_o,
  output logic       key_evt_o,
  output logic [1:0] rst_cause_o
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_RESET      = 2'd0,
    S_SDRAM_HOLD = 2'd1,
    S_WB_HOLD    = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POWER_ON  = 2'd0,
    CAUSE_LOCK_LOSS = 2'd1,
    CAUSE_LONGPRESS = 2'd2
  } cause_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_MAX   = CNT_WIDTH'(LONGPRESS_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LP_LAST  = CNT_WIDTH'(LONGPRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SD_LAST  = CNT_WIDTH'(SDRAM_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WB_LAST  = CNT_WIDTH'(WB_RST_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  // Lock resets to 0 (not locked). The key resets to 1 (released), so that
  // coming out of reset never looks like a press.
  logic r_key_meta;
  logic r_key_s;
  logic r_lock_meta;
  logic r_lock_s;

  // NOTE: non-blocking assignments make every stage sample the previous
  // stage's old value. With blocking assignments the two flops would collapse
  // into a single one and the metastability protection would be lost.
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_key_meta  <= 1'b1;
      r_key_s     <= 1'b1;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_key_meta  <= key_n_i;
      r_key_s     <= r_key_meta;
      r_lock_meta <= pll_locked_i;
      r_lock_s    <= r_lock_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer
  // ---------------------------------------------------------------------------
  // r_db_cnt counts consecutive cycles on which the synchronised key differs
  // from the debounced value. The debounced value flips on the
  // DEBOUNCE_CYCLES-th such cycle in a row. Any cycle on which they agree
  // restarts the count.
  logic                 r_key_db;
  logic [CNT_WIDTH-1:0] r_db_cnt;
  logic                 w_db_flip;
  logic                 w_key_release;

  assign w_db_flip     = (r_key_s != r_key_db) && (r_db_cnt == DB_LAST);
  assign w_key_release = w_db_flip && !r_key_db;

  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_key_db <= 1'b1;
      r_db_cnt <= '0;
    end else if (r_key_s == r_key_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_key_db <= r_key_s;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Press duration
  // ---------------------------------------------------------------------------
  // The counter saturates at LONGPRESS_CYCLES rather than at LONGPRESS_CYCLES-1.
  // This has two effects:
  //  * long_press is asserted for exactly one cycle per press;
  //  * when the key is released, a press that already reached the long-press
  //    threshold (counter == LONGPRESS_CYCLES) cannot also produce key_evt_o.
  logic [CNT_WIDTH-1:0] r_press_cnt;
  logic                 w_long_press;

  assign w_long_press = !r_key_db && (r_press_cnt == LP_LAST);

  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_press_cnt <= '0;
    end else if (r_key_db) begin
      r_press_cnt <= '0;
    end else if (r_press_cnt != LP_MAX) begin
      r_press_cnt <= r_press_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: state register
  // ---------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_seq_cnt;
  logic [CNT_WIDTH-1:0] w_seq_cnt_nxt;
  cause_t               r_cause;
  cause_t               w_cause_nxt;
  logic                 r_sdram_rst;
  logic                 r_wb_rst;
  logic                 w_sdram_rst_nxt;
  logic                 w_wb_rst_nxt;

  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_state     <= S_RESET;
      r_seq_cnt   <= '0;
      r_cause     <= CAUSE_POWER_ON;
      r_sdram_rst <= 1'b1;
      r_wb_rst    <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_seq_cnt   <= w_seq_cnt_nxt;
      r_cause     <= w_cause_nxt;
      r_sdram_rst <= w_sdram_rst_nxt;
      r_wb_rst    <= w_wb_rst_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets its hold value first. A path through
  // the case that left one unassigned would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_seq_cnt_nxt = r_seq_cnt;
    w_cause_nxt   = r_cause;

    unique case (r_state)
      S_RESET: begin
        // Leave reset only once the clock is good and nobody is holding the key.
        if (r_lock_s && r_key_db) begin
          w_state_nxt   = S_SDRAM_HOLD;
          w_seq_cnt_nxt = '0;
        end
      end
      S_SDRAM_HOLD: begin
        if (r_seq_cnt == SD_LAST) begin
          w_state_nxt   = S_WB_HOLD;
          w_seq_cnt_nxt = '0;
        end else begin
          w_seq_cnt_nxt = r_seq_cnt + CNT_ONE;
        end
      end
      S_WB_HOLD: begin
        if (r_seq_cnt == WB_LAST) begin
          w_state_nxt   = S_RUN;
          w_seq_cnt_nxt = '0;
        end else begin
          w_seq_cnt_nxt = r_seq_cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase

    // Abort conditions override the normal progression. Lock loss takes
    // priority over a long press. While in S_RESET neither condition is
    // acted on, so the cause of the previous reset is kept.
    if (r_state != S_RESET) begin
      if (!r_lock_s) begin
        w_state_nxt   = S_RESET;
        w_seq_cnt_nxt = '0;
        w_cause_nxt   = CAUSE_LOCK_LOSS;
      end else if (w_long_press) begin
        w_state_nxt   = S_RESET;
        w_seq_cnt_nxt = '0;
        w_cause_nxt   = CAUSE_LONGPRESS;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: output logic
  // ---------------------------------------------------------------------------
  // The outputs are decoded from the next state and then registered. As a
  // result each reset output changes on the same edge as the state it
  // belongs to.
  always_comb begin
    w_sdram_rst_nxt = (w_state_nxt == S_RESET) || (w_state_nxt == S_SDRAM_HOLD);
    w_wb_rst_nxt    = (w_state_nxt != S_RUN);
  end

  // ---------------------------------------------------------------------------
  // Short-press event
  // ---------------------------------------------------------------------------
  // The pulse is registered together with the debounced release. It is only
  // reported while the SoC is running; a press that reached the long-press
  // threshold is never reported.
  logic r_key_evt;

  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_key_evt <= 1'b0;
    end else begin
      r_key_evt <= w_key_release && (r_press_cnt < LP_MAX) && (r_state == S_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sdram_rst_o = r_sdram_rst;
  assign wb_rst_o    = r_wb_rst;
  assign key_evt_o   = r_key_evt;
  assign rst_cause_o = r_cause;

endmodule
